// File: rtl/cap_refresh_ctrl.sv
// Refresh controller for NCELL leaky charge cells: ages each cell, senses and rewrites it before its charge decays, and serves external writes.
// Latency: a write handshake drives its cell in the next cycle; a refresh takes SENSE then DRIVE (2 cycles).
// Backpressure: wr_ready is low outside IDLE and whenever a refresh is pending, so refresh always wins over a write.
module cap_refresh_ctrl #(
    parameter int NCELL        = 4,
    parameter int DECAY_CYCLES = 32,
    parameter int MARGIN       = 10,
    parameter bit CHECK_MARGIN = 1'b1,
    localparam int AW          = $clog2(NCELL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [AW-1:0]    wr_addr,
    input  logic             wr_data,
    output logic             wr_ready,
    input  logic [NCELL-1:0] cap_q,
    output logic [NCELL-1:0] gate_en,
    output logic             gate_data,
    output logic             busy,
    output logic             decay_err
);

    localparam int AGEW = $clog2(DECAY_CYCLES + 1);
    localparam logic [AGEW-1:0] AGE_MAX  = AGEW'(DECAY_CYCLES);
    localparam logic [AGEW-1:0] AGE_LAST = AGEW'(DECAY_CYCLES - 1);
    localparam logic [AGEW-1:0] AGE_THR  = AGEW'(DECAY_CYCLES - MARGIN);

    // Worst case a cell waits behind every other cell's refresh plus one write;
    // a smaller margin lets a cell decay before its turn comes.
    if (CHECK_MARGIN && (MARGIN < 2 * NCELL + 2)) begin : g_margin_chk
        $error("cap_refresh_ctrl: MARGIN must be >= 2*NCELL+2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SENSE = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              data_q, data_d;
    logic [NCELL-1:0]  valid_q, valid_d;
    logic [AGEW-1:0]   age_q [NCELL];
    logic [AGEW-1:0]   age_d [NCELL];
    logic              decay_q, decay_d;

    logic              refresh_pend;
    logic [AW-1:0]     cand_idx;
    logic [NCELL-1:0]  drive_hit;

    // Lowest-index valid cell past the refresh threshold; scanning downward leaves the lowest hit.
    always_comb begin
        refresh_pend = 1'b0;
        cand_idx     = '0;
        for (int i = NCELL - 1; i >= 0; i--) begin
            if (valid_q[i] && (age_q[i] >= AGE_THR)) begin
                refresh_pend = 1'b1;
                cand_idx     = AW'(i);
            end
        end
    end

    // One-hot gate select for the latched cell; an out-of-range index selects nothing.
    always_comb begin
        drive_hit = '0;
        for (int i = 0; i < NCELL; i++) begin
            drive_hit[i] = (state_q == S_DRIVE) && (idx_q == AW'(i));
        end
    end

    // Per-cell aging: the driven cell restarts at zero, others age and expire at DECAY_CYCLES.
    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        decay_d = 1'b0;
        for (int i = 0; i < NCELL; i++) begin
            if (drive_hit[i]) begin
                age_d[i]   = '0;
                valid_d[i] = 1'b1;
            end else if (valid_q[i]) begin
                if (age_q[i] == AGE_LAST) begin
                    age_d[i]   = AGE_MAX;
                    valid_d[i] = 1'b0;
                    decay_d    = 1'b1;
                end else if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    // Next-state logic: IDLE arbitrates refresh over write, SENSE samples the cell, DRIVE rewrites it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (refresh_pend) begin
                    state_d = S_SENSE;
                    idx_d   = cand_idx;
                end else if (wr_valid) begin
                    state_d = S_DRIVE;
                    idx_d   = wr_addr;
                    data_d  = wr_data;
                end
            end
            S_SENSE: begin
                state_d = S_DRIVE;
                data_d  = cap_q[idx_q];
            end
            S_DRIVE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs; the cell-facing ones are forced quiet while reset is asserted so an aborted DRIVE never reaches a gate.
    always_comb begin
        wr_ready  = (state_q == S_IDLE) && !refresh_pend;
        gate_en   = rst ? '0 : drive_hit;
        gate_data = !rst && (state_q == S_DRIVE) && data_q;
        busy      = !rst && (state_q != S_IDLE);
        decay_err = !rst && decay_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= 1'b0;
            valid_q <= '0;
            decay_q <= 1'b0;
            for (int i = 0; i < NCELL; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            decay_q <= decay_d;
            for (int i = 0; i < NCELL; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cap_refresh_ctrl.sv
// Bench for cap_refresh_ctrl: directed scenarios plus random traffic against a reference model.
// The model tracks cell ages and the remaining cycles of the current operation.
// A second instance with MARGIN=0 shows a starved cell decaying exactly once.
module tb_cap_refresh_ctrl;

    localparam int NC  = 4;
    localparam int D   = 32;
    localparam int M   = 10;
    localparam int THR = D - M;

    logic       clk;
    logic       rst, wr_valid, wr_data, wr_ready, gate_data, busy, decay_err;
    logic [1:0] wr_addr;
    logic [3:0] cap_q, gate_en;

    logic       rst0, wv0, wd0, wr_ready0, gate_data0, busy0, decay_err0;
    logic [1:0] wa0;
    logic [3:0] cap0, gate_en0;

    cap_refresh_ctrl #(.NCELL(NC), .DECAY_CYCLES(D), .MARGIN(M)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .cap_q(cap_q), .gate_en(gate_en), .gate_data(gate_data),
        .busy(busy), .decay_err(decay_err)
    );

    cap_refresh_ctrl #(.NCELL(NC), .DECAY_CYCLES(D), .MARGIN(0), .CHECK_MARGIN(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .wr_valid(wv0), .wr_addr(wa0), .wr_data(wd0),
        .wr_ready(wr_ready0), .cap_q(cap0), .gate_en(gate_en0), .gate_data(gate_data0),
        .busy(busy0), .decay_err(decay_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // Reference model: cell ages/valids and the operation in flight (cycles left, cell, value).
    int   m_age [NC];
    bit   m_vld [NC];
    int   m_left;
    int   m_cell;
    bit   m_val;
    bit   m_dec;
    bit   m_ok = 1'b0;

    logic [3:0] o_gate;
    logic       o_gdat, o_ready, o_busy, o_decay;
    logic [3:0] cap_prev, cap_cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_cand();
        for (int i = 0; i < NC; i++) begin
            if (m_vld[i] && m_age[i] >= THR) return i;
        end
        return -1;
    endfunction

    function automatic bit m_ready();
        return (m_left == 0) && (m_cand() < 0);
    endfunction

    function automatic int oh_idx(input logic [3:0] g);
        for (int i = 0; i < NC; i++) begin
            if (g == (4'd1 << i)) return i;
        end
        return -1;
    endfunction

    task automatic m_step(input bit v, input int a, input bit d, input bit r,
                          input logic [3:0] cap, input int cand);
        if (r) begin
            for (int i = 0; i < NC; i++) begin
                m_age[i] = 0;
                m_vld[i] = 1'b0;
            end
            m_left = 0;
            m_cell = 0;
            m_val  = 1'b0;
            m_dec  = 1'b0;
            m_ok   = 1'b1;
        end else begin
            m_dec = 1'b0;
            for (int i = 0; i < NC; i++) begin
                if (m_left == 1 && m_cell == i) begin
                    m_age[i] = 0;
                    m_vld[i] = 1'b1;
                end else if (m_vld[i]) begin
                    m_age[i]++;
                    if (m_age[i] >= D) begin
                        m_age[i] = D;
                        m_vld[i] = 1'b0;
                        m_dec    = 1'b1;
                    end
                end
            end
            case (m_left)
                0: begin
                    if (cand >= 0) begin
                        m_cell = cand;
                        m_left = 2;
                    end else if (v) begin
                        m_cell = a;
                        m_val  = d;
                        m_left = 1;
                    end
                end
                2: begin
                    m_val  = cap[m_cell];
                    m_left = 1;
                end
                default: m_left = 0;
            endcase
        end
    endtask

    // One clock cycle: apply inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input bit v, input int a, input bit d, input bit r);
        int cand;
        bit act;
        wr_valid = v;
        wr_addr  = 2'(a);
        wr_data  = d;
        rst      = r;
        cap_prev = cap_cur;
        cap_cur  = 4'($urandom);
        cap_q    = cap_cur;
        @(negedge clk);
        o_gate  = gate_en;
        o_gdat  = gate_data;
        o_ready = wr_ready;
        o_busy  = busy;
        o_decay = decay_err;
        cand = m_cand();
        if (m_ok) begin
            act = (m_left == 1) && !r;
            chk("wr_ready",  32'(wr_ready),  32'((m_left == 0) && (cand < 0)));
            chk("busy",      32'(busy),      32'((m_left != 0) && !r));
            chk("gate_en",   32'(gate_en),   act ? (32'd1 << m_cell) : 32'd0);
            chk("gate_data", 32'(gate_data), act ? 32'(m_val) : 32'd0);
            chk("decay_err", 32'(decay_err), 32'(m_dec && !r));
        end
        m_step(v, a, d, r, cap_cur, cand);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        int   first_drv, ndec, k, nact, npulse, pcyc;
        bit   gd, dn;
        logic [3:0] fcap;
        int   drv_cyc [4];
        int   drv_idx [4];
        int   ndrv;

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = 1'b0; cap_q = '0;
        rst0 = 1'b1; wv0 = 1'b0; wa0 = '0; wd0 = 1'b0; cap0 = '0;
        cap_cur = '0; cap_prev = '0;
        @(posedge clk);
        #1;

        // Write to cell 2 straight after reset.
        do_reset();
        cycle(1'b1, 2, 1'b1, 1'b0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_gate",  32'(o_gate),  32'd0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("wr2_gate",  32'(o_gate),  32'b0100);
        chk("wr2_gdat",  32'(o_gdat),  32'd1);
        chk("wr2_busy",  32'(o_busy),  32'd1);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("wr2_ready", 32'(o_ready), 32'd1);
        chk("wr2_idle",  32'(o_busy),  32'd0);

        // Single write to cell 0, then 1000 idle cycles of periodic refresh.
        do_reset();
        cycle(1'b1, 0, 1'($urandom), 1'b0);
        first_drv = -1; ndec = 0; gd = 1'b0; fcap = '0;
        for (int c = 1; c <= 1000; c++) begin
            cycle(1'b0, 0, 1'b0, 1'b0);
            if (o_decay === 1'b1) ndec++;
            if (c > 1 && first_drv < 0 && o_gate === 4'b0001) begin
                first_drv = c;
                gd   = o_gdat;
                fcap = cap_prev;
            end
        end
        chk("ref0_first_drive", 32'(first_drv), 32'd26);
        chk("ref0_gdat",        32'(gd),        32'(fcap[0]));
        chk("ref0_no_decay",    32'(ndec),      32'd0);

        // Writes to all cells on consecutive opportunities, then in-order refreshes.
        do_reset();
        k = 0;
        for (int g = 0; g < 20 && k < 4; g++) begin
            bit hs;
            hs = m_ready();
            cycle(1'b1, k, 1'($urandom), 1'b0);
            if (hs) k++;
        end
        chk("all_writes", 32'(k), 32'd4);
        ndrv = 0; ndec = 0;
        for (int j = 0; j < 100; j++) begin
            cycle(1'b0, 0, 1'b0, 1'b0);
            if (o_decay === 1'b1) ndec++;
            if (j >= 1 && ndrv < 4 && o_gate !== 4'b0000) begin
                drv_cyc[ndrv] = j;
                drv_idx[ndrv] = oh_idx(o_gate);
                ndrv++;
            end
        end
        chk("order_count", 32'(ndrv), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ndrv) chk("order_idx", 32'(drv_idx[i]), 32'(i));
            if (i > 0 && i < ndrv) chk("order_gap", 32'(drv_cyc[i] - drv_cyc[i-1]), 32'd3);
        end
        chk("order_no_decay", 32'(ndec), 32'd0);

        // Write held high as refresh of cell 0 becomes pending; the write lands last.
        do_reset();
        cycle(1'b1, 0, 1'($urandom), 1'b0);
        for (int c = 1; c <= 23; c++) cycle(1'b0, 0, 1'b0, 1'b0);
        dn = 1'($urandom);
        cycle(1'b1, 0, dn, 1'b0);
        chk("pend_ready", 32'(o_ready), 32'd0);
        cycle(1'b1, 0, dn, 1'b0);
        chk("pend_sense_busy", 32'(o_busy), 32'd1);
        chk("pend_sense_gate", 32'(o_gate), 32'd0);
        cycle(1'b1, 0, dn, 1'b0);
        chk("pend_drive_gate", 32'(o_gate), 32'b0001);
        cycle(1'b1, 0, dn, 1'b0);
        chk("pend_wr_ready", 32'(o_ready), 32'd1);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("pend_wr_gate", 32'(o_gate), 32'b0001);
        chk("pend_wr_gdat", 32'(o_gdat), 32'(dn));

        // Reset pulsed during a DRIVE aborts it and leaves nothing to refresh.
        do_reset();
        cycle(1'b1, 2, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("abort_gate",  32'(o_gate),  32'd0);
        chk("abort_busy",  32'(o_busy),  32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        nact = 0;
        for (int c = 0; c < 100; c++) begin
            cycle(1'b0, 0, 1'b0, 1'b0);
            if (o_gate !== 4'b0000 || o_busy !== 1'b0) nact++;
        end
        chk("abort_quiet", 32'(nact), 32'd0);

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 299) == 0));
        end

        // MARGIN=0 instance: writes to cell 1 forever starve cell 0 into decay.
        rst = 1'b1;
        wr_valid = 1'b0;
        npulse = 0; pcyc = -1;
        for (int c = 0; c < 100; c++) begin
            rst0 = 1'b0;
            wv0  = 1'b1;
            wa0  = (c == 0) ? 2'd0 : 2'd1;
            wd0  = 1'(c & 1);
            cap0 = 4'($urandom);
            @(negedge clk);
            if (decay_err0 === 1'b1) begin
                npulse++;
                if (pcyc < 0) pcyc = c;
            end
            @(posedge clk);
            #1;
        end
        chk("starve_pulses", 32'(npulse), 32'd1);
        chk("starve_cycle",  32'(pcyc),   32'd34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
